// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: issues one word read at a time to instruction
// memory, buffers {pc, instr} pairs in a small FIFO for decode, pulses pc_en
// when a fetch completes, and discards buffered and in-flight work on flush.
module instr_fetch_ctrl #(
   parameter int unsigned DEPTH      = 2,
   parameter logic [31:0] RESET_ADDR = 32'h00400000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] pc_in,
   output logic        pc_en,
   input  logic        flush,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        if_valid,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   input  logic        if_ready,
   output logic        fetch_err
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] DepthC = CW'(DEPTH);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StBusy = 2'd1;
   localparam logic [1:0] StDrop = 2'd2;

   logic [1:0]    state_q, state_d;
   logic          req_q, req_d;
   logic [31:0]   addr_q, addr_d;
   logic          err_q, err_d;
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q;
   logic [CW-1:0] count_after_pop;
   logic [31:0]   pc_mem_q    [DEPTH];
   logic [31:0]   instr_mem_q [DEPTH];
   logic          push, pop;

   assign if_valid  = (count_q != '0);
   assign if_pc     = pc_mem_q[rd_ptr_q];
   assign if_instr  = instr_mem_q[rd_ptr_q];
   assign imem_req  = req_q;
   assign imem_addr = addr_q;
   assign fetch_err = err_q;

   // Completion pulse: only a clean ack in BUSY advances the PC.
   assign pc_en = (state_q == StBusy) && imem_ack && !flush && !err_q;

   // Pop is suppressed by flush so the flush clear always wins.
   assign pop             = if_valid && if_ready && !flush;
   assign count_after_pop = count_q - CW'(pop);

   // Next-state logic for the request FSM, address register and error flag.
   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      addr_d  = addr_q;
      err_d   = err_q;
      push    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (!flush) begin
               if (pc_in[1:0] != 2'b00) begin
                  err_d = 1'b1;
               end else if (!err_q && (count_after_pop < DepthC)) begin
                  addr_d  = pc_in;
                  req_d   = 1'b1;
                  state_d = StBusy;
               end
            end
         end
         StBusy: begin
            if (imem_ack) begin
               req_d   = 1'b0;
               state_d = StIdle;
               push    = !flush;
            end else if (flush) begin
               // Request must stay up until memory acks; the data is dropped.
               state_d = StDrop;
            end
         end
         StDrop: begin
            if (imem_ack) begin
               req_d   = 1'b0;
               state_d = StIdle;
            end
         end
         default: begin
            req_d   = 1'b0;
            state_d = StIdle;
         end
      endcase
      if (flush) begin
         err_d = 1'b0;
      end
   end

   // Control state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         req_q   <= 1'b0;
         addr_q  <= RESET_ADDR;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         addr_q  <= addr_d;
         err_q   <= err_d;
      end
   end

   // FIFO storage, pointers and occupancy; flush empties it outright.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            pc_mem_q[i]    <= '0;
            instr_mem_q[i] <= '0;
         end
      end else if (flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            pc_mem_q[wr_ptr_q]    <= addr_q;
            instr_mem_q[wr_ptr_q] <= imem_rdata;
            wr_ptr_q              <= wr_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PW'(1);
         end
         count_q <= count_q + CW'(push) - CW'(pop);
      end
   end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl: a memory model with configurable ack
// latency, a PC register model that advances by 4 on pc_en, and one task per
// scenario with hand-computed expectations.
module tb_instr_fetch_ctrl;

   logic        clk, rst_n, flush, imem_ack, if_ready;
   logic        pc_en, imem_req, if_valid, fetch_err;
   logic [31:0] pc_in, imem_addr, imem_rdata, if_instr, if_pc;

   int   checks = 0;
   int   failures = 0;
   int   ack_lat = 0;
   int   wc = 0;
   int   pc_en_cnt = 0;
   logic pc_en_seen = 1'b0;

   instr_fetch_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .pc_in      (pc_in),
      .pc_en      (pc_en),
      .flush      (flush),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .if_valid   (if_valid),
      .if_instr   (if_instr),
      .if_pc      (if_pc),
      .if_ready   (if_ready),
      .fetch_err  (fetch_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a == 32'h00400000) ? 32'h20080005 : (a ^ 32'hA5A50000);
   endfunction

   // Memory: acks after ack_lat wait cycles of a raised request.
   initial begin
      imem_ack   = 1'b0;
      imem_rdata = '0;
      forever begin
         @(posedge clk); #1;
         if (!imem_req) begin
            imem_ack = 1'b0;
            wc = 0;
         end else if (wc >= ack_lat) begin
            imem_ack   = 1'b1;
            imem_rdata = mem_word(imem_addr);
            wc = 0;
         end else begin
            imem_ack = 1'b0;
            wc++;
         end
      end
   end

   // PC register: loads pc_in + 4 on the edge that ends a pc_en cycle.
   initial begin
      forever begin
         @(negedge clk); #1;
         pc_en_seen = pc_en;
         if (pc_en) pc_en_cnt++;
         @(posedge clk); #1;
         if (pc_en_seen) pc_in = pc_in + 32'd4;
      end
   end

   task automatic apply_reset(input logic [31:0] pc, input logic rdy, input int lat);
      rst_n    = 1'b0;
      flush    = 1'b0;
      pc_in    = pc;
      if_ready = rdy;
      ack_lat  = lat;
      repeat (2) @(posedge clk);
      #1;
      pc_en_cnt = 0;
      rst_n     = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; flush = 1'b0; if_ready = 1'b0; pc_in = 32'h00400000; ack_lat = 0;
      @(negedge clk);
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req: got %0b want 0", imem_req); end
      checks++; if (imem_addr !== 32'h00400000) begin failures++; $display("FAIL reset_addr: got %h want 00400000", imem_addr); end
      checks++; if (pc_en !== 1'b0) begin failures++; $display("FAIL reset_pc_en: got %0b want 0", pc_en); end
      checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %0b want 0", if_valid); end
      checks++; if (if_instr !== 32'h0) begin failures++; $display("FAIL reset_instr: got %h want 0", if_instr); end
      checks++; if (if_pc !== 32'h0) begin failures++; $display("FAIL reset_pc: got %h want 0", if_pc); end
      checks++; if (fetch_err !== 1'b0) begin failures++; $display("FAIL reset_err: got %0b want 0", fetch_err); end
   endtask

   task automatic test_basic();
      apply_reset(32'h00400000, 1'b1, 0);
      @(negedge clk); // cycle 0
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL basic_req_c0: got %0b want 0", imem_req); end
      @(negedge clk); // cycle 1
      checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL basic_req_c1: got %0b want 1", imem_req); end
      checks++; if (pc_en !== 1'b1) begin failures++; $display("FAIL basic_pc_en_c1: got %0b want 1", pc_en); end
      checks++; if (imem_addr !== 32'h00400000) begin failures++; $display("FAIL basic_addr: got %h want 00400000", imem_addr); end
      @(negedge clk); // cycle 2
      checks++; if (if_valid !== 1'b1) begin failures++; $display("FAIL basic_valid: got %0b want 1", if_valid); end
      checks++; if (if_pc !== 32'h00400000) begin failures++; $display("FAIL basic_if_pc: got %h want 00400000", if_pc); end
      checks++; if (if_instr !== 32'h20080005) begin failures++; $display("FAIL basic_if_instr: got %h want 20080005", if_instr); end
      checks++; if (pc_en !== 1'b0) begin failures++; $display("FAIL basic_pc_en_c2: got %0b want 0", pc_en); end
   endtask

   task automatic test_backpressure();
      apply_reset(32'h00400000, 1'b0, 3);
      repeat (20) @(negedge clk);
      checks++; if (pc_en_cnt != 2) begin failures++; $display("FAIL bp_fetch_count: got %0d want 2", pc_en_cnt); end
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL bp_req_full: got %0b want 0", imem_req); end
      checks++; if (if_pc !== 32'h00400000) begin failures++; $display("FAIL bp_head_pc: got %h want 00400000", if_pc); end
      checks++; if (if_instr !== 32'h20080005) begin failures++; $display("FAIL bp_head_instr: got %h want 20080005", if_instr); end
      @(posedge clk); #1;
      if_ready = 1'b1;
      @(negedge clk);
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL bp_req_pop_cycle: got %0b want 0", imem_req); end
      @(negedge clk);
      checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL bp_req_after_pop: got %0b want 1", imem_req); end
      checks++; if (imem_addr !== 32'h00400008) begin failures++; $display("FAIL bp_next_addr: got %h want 00400008", imem_addr); end
      checks++; if (if_pc !== 32'h00400004) begin failures++; $display("FAIL bp_second_pc: got %h want 00400004", if_pc); end
      checks++; if (if_instr !== 32'hA5E50004) begin failures++; $display("FAIL bp_second_instr: got %h want a5e50004", if_instr); end
      @(negedge clk);
      checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL bp_drained: got %0b want 0", if_valid); end
   endtask

   task automatic test_flush_drop();
      apply_reset(32'h00400000, 1'b1, 3);
      @(posedge clk); #1; // cycle 1: first wait cycle
      @(posedge clk); #1; // cycle 2: second wait cycle
      flush = 1'b1;
      pc_in = 32'h00400040;
      @(negedge clk);
      checks++; if (pc_en !== 1'b0) begin failures++; $display("FAIL drop_pc_en_flush: got %0b want 0", pc_en); end
      @(posedge clk); #1;
      flush = 1'b0;
      @(negedge clk); // cycle 3: DROP
      checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL drop_req_held: got %0b want 1", imem_req); end
      @(negedge clk); // cycle 4: ack of dropped fetch
      checks++; if (pc_en !== 1'b0) begin failures++; $display("FAIL drop_pc_en_ack: got %0b want 0", pc_en); end
      @(negedge clk); // cycle 5
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL drop_req_released: got %0b want 0", imem_req); end
      checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL drop_no_push: got %0b want 0", if_valid); end
      @(negedge clk); // cycle 6
      checks++; if (imem_addr !== 32'h00400040) begin failures++; $display("FAIL drop_redirect_addr: got %h want 00400040", imem_addr); end
      checks++; if (pc_en_cnt != 0) begin failures++; $display("FAIL drop_pc_en_count: got %0d want 0", pc_en_cnt); end
   endtask

   task automatic test_flush_ack_full();
      apply_reset(32'h00400000, 1'b0, 3);
      repeat (20) @(negedge clk);
      ack_lat = 0;
      @(posedge clk); #1;
      if_ready = 1'b1;
      @(posedge clk); #1;
      flush = 1'b1;
      pc_in = 32'h00400080;
      @(negedge clk);
      checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL fa_req_in_ack: got %0b want 1", imem_req); end
      checks++; if (pc_en !== 1'b0) begin failures++; $display("FAIL fa_pc_en: got %0b want 0", pc_en); end
      @(posedge clk); #1;
      flush    = 1'b0;
      if_ready = 1'b0;
      @(negedge clk);
      checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL fa_emptied: got %0b want 0", if_valid); end
      @(negedge clk);
      checks++; if (imem_addr !== 32'h00400080) begin failures++; $display("FAIL fa_redirect_addr: got %h want 00400080", imem_addr); end
      @(negedge clk);
      checks++; if (if_pc !== 32'h00400080) begin failures++; $display("FAIL fa_head_pc: got %h want 00400080", if_pc); end
      checks++; if (if_instr !== 32'hA5E50080) begin failures++; $display("FAIL fa_head_instr: got %h want a5e50080", if_instr); end
   endtask

   task automatic test_misaligned();
      apply_reset(32'h00400002, 1'b1, 0);
      @(negedge clk); // cycle 0
      checks++; if (fetch_err !== 1'b0) begin failures++; $display("FAIL mis_err_c0: got %0b want 0", fetch_err); end
      @(negedge clk); // cycle 1
      checks++; if (fetch_err !== 1'b1) begin failures++; $display("FAIL mis_err_set: got %0b want 1", fetch_err); end
      repeat (2) @(negedge clk); // cycle 3
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL mis_no_req: got %0b want 0", imem_req); end
      checks++; if (pc_en_cnt != 0) begin failures++; $display("FAIL mis_no_pc_en: got %0d want 0", pc_en_cnt); end
      @(posedge clk); #1;
      flush = 1'b1;
      pc_in = 32'h00400008;
      @(posedge clk); #1;
      flush = 1'b0;
      @(negedge clk); // cycle 5
      checks++; if (fetch_err !== 1'b0) begin failures++; $display("FAIL mis_err_cleared: got %0b want 0", fetch_err); end
      @(negedge clk); // cycle 6
      checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL mis_resume_req: got %0b want 1", imem_req); end
      checks++; if (imem_addr !== 32'h00400008) begin failures++; $display("FAIL mis_resume_addr: got %h want 00400008", imem_addr); end
      @(negedge clk); // cycle 7
      checks++; if (if_pc !== 32'h00400008) begin failures++; $display("FAIL mis_resume_pc: got %h want 00400008", if_pc); end
   endtask

   task automatic test_async_reset();
      apply_reset(32'h00400000, 1'b0, 0);
      @(negedge clk); // cycle 0
      @(negedge clk); // cycle 1: first fetch acks
      ack_lat = 3;
      @(negedge clk); // cycle 2
      @(negedge clk); // cycle 3: second fetch in flight
      checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL ar_busy_req: got %0b want 1", imem_req); end
      checks++; if (if_valid !== 1'b1) begin failures++; $display("FAIL ar_busy_valid: got %0b want 1", if_valid); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL ar_req: got %0b want 0", imem_req); end
      checks++; if (imem_addr !== 32'h00400000) begin failures++; $display("FAIL ar_addr: got %h want 00400000", imem_addr); end
      checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL ar_valid: got %0b want 0", if_valid); end
      checks++; if (if_pc !== 32'h0) begin failures++; $display("FAIL ar_if_pc: got %h want 0", if_pc); end
      pc_in   = 32'h00400100;
      ack_lat = 0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk); // cycle 0
      @(negedge clk); // cycle 1
      checks++; if (imem_addr !== 32'h00400100) begin failures++; $display("FAIL ar_restart_addr: got %h want 00400100", imem_addr); end
      @(negedge clk); // cycle 2
      checks++; if (if_pc !== 32'h00400100) begin failures++; $display("FAIL ar_restart_head: got %h want 00400100", if_pc); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_flush_drop();
      test_flush_ack_full();
      test_misaligned();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/instr_fetch_ctrl.md
Name: instr_fetch_ctrl

Overview:
Fetch controller directly downstream of the PC register in the MIPS datapath. It consumes the current PC and issues word reads to instruction memory over a req/ack handshake. Fetched {PC, instruction} pairs are buffered in a small FIFO for decode, and a one-cycle pc_en pulse tells the PC register to advance. A flush input discards buffered and in-flight fetches on branch/jump redirect.

Parameters:
DEPTH, 2, FIFO entries (power of two, at least 2)
RESET_ADDR, 32'h00400000, reset value of the imem_addr register

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
pc_in  input  32  current PC from the PC register
pc_en  output  1  one-cycle pulse; PC register loads next_PC on this edge
flush  input  1  redirect; discard FIFO and any in-flight fetch
imem_req  output  1  read request to instruction memory
imem_addr  output  32  word address of the request, registered
imem_ack  input  1  memory accepts the request and returns data in the same cycle
imem_rdata  input  32  instruction word, valid when imem_ack=1
if_valid  output  1  FIFO head is valid
if_instr  output  32  FIFO head instruction
if_pc  output  32  FIFO head PC
if_ready  input  1  decode consumes the head when if_valid=1
fetch_err  output  1  sticky misaligned-PC flag

Behaviour:
- Reset (rst_n=0, async): state=IDLE, imem_req=0, imem_addr=RESET_ADDR, pc_en=0, FIFO count=0, if_valid=0, if_instr=0, if_pc=0, fetch_err=0.
- FSM states: IDLE, BUSY, DROP.
- IDLE: if flush=0, fetch_err=0, pc_in[1:0]=0 and count<DEPTH, then register imem_addr<=pc_in, set imem_req<=1 and go to BUSY.
- IDLE: if pc_in[1:0]!=0, set fetch_err<=1 and issue no request.
- BUSY: imem_req=1; imem_addr is held stable until ack.
- BUSY, imem_ack=1, flush=0: push {imem_addr, imem_rdata}, pulse pc_en=1 for exactly this cycle, imem_req<=0, go to IDLE.
- BUSY, flush=1 and imem_ack=0: go to DROP; imem_req stays 1.
- BUSY, flush=1 and imem_ack=1: data is discarded, pc_en=0, go to IDLE.
- DROP: imem_req=1 until imem_ack; the acked data is discarded, pc_en=0, then go to IDLE.
- Flush during DROP keeps the state at DROP.
- Only one outstanding request at a time. Minimum issue interval is 2 cycles (IDLE then BUSY).
- The request decision in IDLE samples count after this cycle's pop, so a pop and an issue may occur in the same cycle.
- A push can never overflow: a request is only issued when a slot is free, and nothing else pushes while BUSY.
- Pop: if_valid && if_ready removes the head; the next entry becomes visible the following cycle.
- Simultaneous push and pop: count is unchanged and entry order is preserved.
- Empty FIFO: if_valid=0; if_instr and if_pc hold their last value (don't-care).
- Flush: count<=0 and if_valid=0 on the next cycle, overriding any same-cycle push or pop. Flush also clears fetch_err.
- pc_en is never asserted outside BUSY-with-ack, and never while fetch_err=1.
- Pointers wrap modulo DEPTH; count is clog2(DEPTH)+1 bits wide.

Test Plan:
- Reset, pc_in=0x00400000, memory acks in the request cycle with 0x20080005, if_ready=1 -> imem_req rises in cycle 1, pc_en pulses in cycle 1, and if_valid=1 with if_pc=0x00400000, if_instr=0x20080005 in cycle 2.
- if_ready=0 with 3-cycle ack latency -> exactly 2 entries fetched (0x00400000, 0x00400004), then imem_req stays 0. Raising if_ready yields entries in order, and the next request issues the same cycle as the first pop.
- flush asserted in the 2nd wait cycle of an in-flight fetch -> DROP, imem_req held until ack, no push, no pc_en. FIFO is empty next cycle, and the next request uses the redirected pc_in=0x00400040.
- flush and imem_ack in the same cycle with a full FIFO and if_ready=1 -> count=0, pc_en=0, acked data not visible.
- pc_in=0x00400002 -> fetch_err=1, no imem_req, no pc_en. flush with pc_in=0x00400008 clears the error and fetching resumes.
- rst_n dropped mid-BUSY -> outputs return to reset values immediately (asynchronously). After release, fetching restarts from pc_in with an empty FIFO.
